// File: rtl/chip8_pkg.sv
// chip8_pkg: shared system-state/PC-select enums and opcode field constants for the CHIP-8 core.
package chip8_pkg;
  typedef enum logic [1:0] {
    CHIP8_RESET,
    CHIP8_RUNNING,
    CHIP8_PAUSED,
    CHIP8_HALTED
  } Chip8_STATE;
  typedef enum logic [1:0] {
    PC_SRC_NEXT,
    PC_SRC_JUMP,
    PC_SRC_SKIP
  } PC_SRC;
  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_JP   = 4'h1;
  localparam logic [3:0] OP_SE   = 4'h3;
  localparam logic [3:0] OP_SNE  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_MISC = 4'hF;
  localparam logic [3:0] ALU_MOV = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [7:0] SYS_CLS    = 8'hE0;
  localparam logic [7:0] F_GET_DT   = 8'h07;
  localparam logic [7:0] F_WAIT_KEY = 8'h0A;
  localparam logic [7:0] F_SET_DT   = 8'h15;
  localparam logic [7:0] F_SET_ST   = 8'h18;
  localparam logic [3:0] VF = 4'hF;
endpackage

// File: rtl/chip8_alu.sv
// chip8_alu: 8-bit add with carry-out for 7xkk and 8xy4.
module chip8_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/chip8_cpu.sv
// chip8_cpu: stage-sequenced combinational instruction decoder driving register, timer, PC and framebuffer controls.
module chip8_cpu
  import chip8_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic [15:0] instruction,
  input  logic [31:0] stage,
  input  Chip8_STATE  top_level_state,
  input  logic [7:0]  reg_readdata1,
  input  logic [7:0]  reg_readdata2,
  input  logic [7:0]  mem_readdata1,
  input  logic [7:0]  mem_readdata2,
  input  logic [15:0] reg_I_readdata,
  input  logic [7:0]  delay_timer_readdata,
  input  logic [11:0] PC_readdata,
  input  logic        fb_readdata,
  input  logic        key_pressed,
  input  logic [3:0]  key_press,
  output logic [3:0]  reg_addr1,
  output logic [3:0]  reg_addr2,
  output logic [7:0]  reg_writedata1,
  output logic [7:0]  reg_writedata2,
  output logic        reg_WE1,
  output logic        reg_WE2,
  output logic [11:0] mem_addr1,
  output logic [11:0] mem_addr2,
  output logic [7:0]  mem_writedata1,
  output logic [7:0]  mem_writedata2,
  output logic        mem_WE1,
  output logic        mem_WE2,
  output logic [15:0] reg_I_writedata,
  output logic        reg_I_WE,
  output logic [7:0]  delay_timer_writedata,
  output logic [7:0]  sound_timer_writedata,
  output logic        delay_timer_WE,
  output logic        sound_timer_WE,
  output PC_SRC       pc_src,
  output logic [11:0] PC_writedata,
  output logic        sp_push,
  output logic        sp_pop,
  output logic [4:0]  fb_addr_y,
  output logic [5:0]  fb_addr_x,
  output logic        fb_writedata,
  output logic        fb_WE,
  output logic        fbreset,
  output logic        halt_for_keypress
);
  logic [3:0]  op, x, y, n;
  logic [7:0]  kk, alu_b, alu_sum;
  logic [11:0] nnn;
  logic        alu_carry, s2, s3, s2p, run_d, run_q, unused;
  assign op  = instruction[15:12];
  assign x   = instruction[11:8];
  assign y   = instruction[7:4];
  assign n   = instruction[3:0];
  assign kk  = instruction[7:0];
  assign nnn = instruction[11:0];
  assign s2  = stage == 32'd2;
  assign s3  = stage == 32'd3;
  assign s2p = stage >= 32'd2;
  assign alu_b = (op == OP_ALU) ? reg_readdata2 : kk;
  assign unused = ^{mem_readdata1, mem_readdata2, reg_I_readdata, PC_readdata, fb_readdata};
  assign {mem_addr1, mem_addr2, mem_writedata1, mem_writedata2, mem_WE1, mem_WE2} = '0;
  assign {sp_push, sp_pop, fb_addr_y, fb_addr_x, fb_writedata, fb_WE} = '0;
  chip8_alu u_alu (
    .a     (reg_readdata1),
    .b     (alu_b),
    .sum   (alu_sum),
    .carry (alu_carry)
  );
  // Outputs stay at defaults from reset assertion until the first clock after release.
  assign run_d = 1'b1;
  always_ff @(posedge cpu_clk or negedge reset_n)
    if (!reset_n) run_q <= 1'b0;
    else run_q <= run_d;
  always_comb begin
    reg_addr1 = '0;
    reg_addr2 = '0;
    reg_writedata1 = '0;
    reg_writedata2 = '0;
    reg_WE1 = 1'b0;
    reg_WE2 = 1'b0;
    reg_I_writedata = '0;
    reg_I_WE = 1'b0;
    delay_timer_writedata = '0;
    sound_timer_writedata = '0;
    delay_timer_WE = 1'b0;
    sound_timer_WE = 1'b0;
    pc_src = PC_SRC_NEXT;
    PC_writedata = '0;
    fbreset = 1'b0;
    halt_for_keypress = 1'b0;
    if (run_q && top_level_state == CHIP8_RUNNING) begin
      case (op)
        OP_SYS: fbreset = s2 && x == 4'h0 && kk == SYS_CLS;
        OP_JP: if (s2) begin
          pc_src = PC_SRC_JUMP;
          PC_writedata = nnn;
        end
        OP_LDI: if (s2) begin
          reg_I_WE = 1'b1;
          reg_I_writedata = {4'h0, nnn};
        end
        OP_LD: if (s2) begin
          reg_addr1 = x;
          reg_writedata1 = kk;
          reg_WE1 = 1'b1;
        end
        OP_ADD: begin
          reg_addr1 = (s2 || s3) ? x : 4'h0;
          reg_writedata1 = s3 ? alu_sum : 8'h00;
          reg_WE1 = s3;
        end
        // Read addresses are held through stage 3 so the combinational read data stays valid.
        OP_SE, OP_SNE: begin
          reg_addr1 = (s2 || s3) ? x : 4'h0;
          if (s3 && ((reg_readdata1 == kk) ^ (op == OP_SNE))) pc_src = PC_SRC_SKIP;
        end
        OP_ALU: if ((n == ALU_MOV || n == ALU_ADD) && (s2 || s3)) begin
          reg_addr1 = x;
          reg_addr2 = y;
          if (s3 && n == ALU_MOV) begin
            reg_writedata1 = reg_readdata2;
            reg_WE1 = 1'b1;
          end
          // VF carry write must win when x is F, so the sum write is suppressed then.
          if (s3 && n == ALU_ADD) begin
            reg_writedata1 = alu_sum;
            reg_WE1 = x != VF;
            reg_addr2 = VF;
            reg_writedata2 = {7'b0, alu_carry};
            reg_WE2 = 1'b1;
          end
        end
        OP_MISC: begin
          if (kk == F_GET_DT && s2) begin
            reg_addr1 = x;
            reg_writedata1 = delay_timer_readdata;
            reg_WE1 = 1'b1;
          end
          if ((kk == F_SET_DT || kk == F_SET_ST) && (s2 || s3)) begin
            reg_addr1 = x;
            delay_timer_WE = s3 && kk == F_SET_DT;
            sound_timer_WE = s3 && kk == F_SET_ST;
            delay_timer_writedata = (s3 && kk == F_SET_DT) ? reg_readdata1 : 8'h00;
            sound_timer_writedata = (s3 && kk == F_SET_ST) ? reg_readdata1 : 8'h00;
          end
          if (kk == F_WAIT_KEY && s2p) begin
            halt_for_keypress = !key_pressed;
            reg_addr1 = key_pressed ? x : 4'h0;
            reg_writedata1 = key_pressed ? {4'h0, key_press} : 8'h00;
            reg_WE1 = key_pressed;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_cpu.sv
// tb_chip8_cpu: directed scoreboard bench comparing every chip8_cpu output per instruction stage.
module tb_chip8_cpu;
  import chip8_pkg::*;
  typedef struct packed {
    logic [3:0]  reg_addr1, reg_addr2;
    logic [7:0]  reg_writedata1, reg_writedata2;
    logic        reg_WE1, reg_WE2;
    logic [11:0] mem_addr1, mem_addr2;
    logic [7:0]  mem_writedata1, mem_writedata2;
    logic        mem_WE1, mem_WE2;
    logic [15:0] reg_I_writedata;
    logic        reg_I_WE;
    logic [7:0]  delay_timer_writedata, sound_timer_writedata;
    logic        delay_timer_WE, sound_timer_WE;
    logic [1:0]  pc_src;
    logic [11:0] PC_writedata;
    logic        sp_push, sp_pop;
    logic [4:0]  fb_addr_y;
    logic [5:0]  fb_addr_x;
    logic        fb_writedata, fb_WE, fbreset, halt_for_keypress;
  } out_t;
  typedef struct {
    string tag;
    out_t  exp;
    out_t  msk;
  } sb_t;
  logic cpu_clk = 1'b0, reset_n = 1'b0;
  logic [15:0] instruction = '0;
  logic [31:0] stage = '0;
  Chip8_STATE top_level_state = CHIP8_RUNNING;
  logic [7:0] reg_readdata1 = '0, reg_readdata2 = '0, mem_readdata1 = '0, mem_readdata2 = '0;
  logic [15:0] reg_I_readdata = '0;
  logic [7:0] delay_timer_readdata = '0;
  logic [11:0] PC_readdata = '0;
  logic fb_readdata = 1'b0, key_pressed = 1'b0;
  logic [3:0] key_press = '0;
  logic [3:0] reg_addr1, reg_addr2;
  logic [7:0] reg_writedata1, reg_writedata2, mem_writedata1, mem_writedata2;
  logic reg_WE1, reg_WE2, mem_WE1, mem_WE2, reg_I_WE, delay_timer_WE, sound_timer_WE;
  logic [11:0] mem_addr1, mem_addr2, PC_writedata;
  logic [15:0] reg_I_writedata;
  logic [7:0] delay_timer_writedata, sound_timer_writedata;
  PC_SRC pc_src;
  logic sp_push, sp_pop, fb_writedata, fb_WE, fbreset, halt_for_keypress;
  logic [4:0] fb_addr_y;
  logic [5:0] fb_addr_x;
  out_t obs, e, m;
  sb_t sb[$];
  int errors = 0, checks = 0;
  chip8_cpu dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .instruction(instruction), .stage(stage),
    .top_level_state(top_level_state), .reg_readdata1(reg_readdata1), .reg_readdata2(reg_readdata2),
    .mem_readdata1(mem_readdata1), .mem_readdata2(mem_readdata2), .reg_I_readdata(reg_I_readdata),
    .delay_timer_readdata(delay_timer_readdata), .PC_readdata(PC_readdata), .fb_readdata(fb_readdata),
    .key_pressed(key_pressed), .key_press(key_press), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_writedata1(reg_writedata1), .reg_writedata2(reg_writedata2), .reg_WE1(reg_WE1), .reg_WE2(reg_WE2),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_writedata1(mem_writedata1),
    .mem_writedata2(mem_writedata2), .mem_WE1(mem_WE1), .mem_WE2(mem_WE2),
    .reg_I_writedata(reg_I_writedata), .reg_I_WE(reg_I_WE), .delay_timer_writedata(delay_timer_writedata),
    .sound_timer_writedata(sound_timer_writedata), .delay_timer_WE(delay_timer_WE),
    .sound_timer_WE(sound_timer_WE), .pc_src(pc_src), .PC_writedata(PC_writedata), .sp_push(sp_push),
    .sp_pop(sp_pop), .fb_addr_y(fb_addr_y), .fb_addr_x(fb_addr_x), .fb_writedata(fb_writedata),
    .fb_WE(fb_WE), .fbreset(fbreset), .halt_for_keypress(halt_for_keypress)
  );
  assign obs = {reg_addr1, reg_addr2, reg_writedata1, reg_writedata2, reg_WE1, reg_WE2,
                mem_addr1, mem_addr2, mem_writedata1, mem_writedata2, mem_WE1, mem_WE2,
                reg_I_writedata, reg_I_WE, delay_timer_writedata, sound_timer_writedata,
                delay_timer_WE, sound_timer_WE, pc_src, PC_writedata, sp_push, sp_pop,
                fb_addr_y, fb_addr_x, fb_writedata, fb_WE, fbreset, halt_for_keypress};
  always #5 cpu_clk = ~cpu_clk;
  task automatic clr();
    e = '0;
    e.pc_src = PC_SRC_NEXT;
    m = '1;
  endtask
  task automatic drive(input logic [15:0] ins, input logic [31:0] stg);
    @(posedge cpu_clk);
    #1;
    instruction = ins;
    stage = stg;
    clr();
  endtask
  task automatic chk();
    sb_t t;
    t = sb.pop_front();
    checks++;
    assert ((obs & t.msk) === (t.exp & t.msk)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t.tag, obs & t.msk, t.exp & t.msk);
    end
  endtask
  task automatic now(input string tag);
    sb.push_back('{tag, e, m});
    #1;
    chk();
  endtask
  task automatic fin(input string tag);
    sb.push_back('{tag, e, m});
    @(negedge cpu_clk);
    chk();
  endtask
  initial begin
    instruction = 16'h61F0;
    stage = 2;
    clr();
    #3 now("reset");
    @(negedge cpu_clk) reset_n = 1'b1;
    drive(16'h61F0, 0); fin("fetch_s0");
    drive(16'h61F0, 2); e.reg_addr1 = 4'h1; e.reg_writedata1 = 8'hF0; e.reg_WE1 = 1; fin("ld_s2");
    drive(16'h61F0, 3); fin("ld_s3");
    reg_readdata1 = 8'h01;
    drive(16'h7EF0, 2); e.reg_addr1 = 4'hE; fin("add_s2");
    drive(16'h7EF0, 3); e.reg_addr1 = 4'hE; e.reg_writedata1 = 8'hF1; e.reg_WE1 = 1; fin("add_s3");
    drive(16'h7EF0, 4); fin("add_s4");
    reg_readdata1 = 8'hFF;
    drive(16'h7302, 3); e.reg_addr1 = 4'h3; e.reg_writedata1 = 8'h01; e.reg_WE1 = 1; fin("add_wrap");
    reg_readdata2 = 8'h5A;
    drive(16'h8120, 2); e.reg_addr1 = 4'h1; e.reg_addr2 = 4'h2; fin("mov_s2");
    drive(16'h8120, 3); e.reg_addr1 = 4'h1; e.reg_writedata1 = 8'h5A; e.reg_WE1 = 1; m.reg_addr2 = '0; fin("mov_s3");
    reg_readdata1 = 8'hF0; reg_readdata2 = 8'h20;
    drive(16'h8124, 2); e.reg_addr1 = 4'h1; e.reg_addr2 = 4'h2; fin("addc_s2");
    drive(16'h8124, 3); e.reg_addr1 = 4'h1; e.reg_writedata1 = 8'h10; e.reg_WE1 = 1;
    e.reg_addr2 = 4'hF; e.reg_writedata2 = 8'h01; e.reg_WE2 = 1; fin("addc_s3");
    reg_readdata1 = 8'h10;
    drive(16'h8124, 3); e.reg_addr1 = 4'h1; e.reg_writedata1 = 8'h30; e.reg_WE1 = 1;
    e.reg_addr2 = 4'hF; e.reg_WE2 = 1; fin("addnc_s3");
    reg_readdata1 = 8'hF0;
    drive(16'h8F24, 3); e.reg_addr2 = 4'hF; e.reg_writedata2 = 8'h01; e.reg_WE2 = 1;
    m.reg_addr1 = '0; m.reg_writedata1 = '0; fin("addvf_s3");
    drive(16'h8125, 3); fin("alu_undec");
    drive(16'hA123, 2); e.reg_I_WE = 1; e.reg_I_writedata = 16'h0123; fin("ldi_s2");
    drive(16'h1ABC, 2); e.pc_src = PC_SRC_JUMP; e.PC_writedata = 12'hABC; fin("jp_s2");
    drive(16'h1ABC, 3); fin("jp_s3");
    drive(16'h3455, 2); e.reg_addr1 = 4'h4; fin("se_s2");
    reg_readdata1 = 8'h55;
    drive(16'h3455, 3); e.pc_src = PC_SRC_SKIP; m.reg_addr1 = '0; fin("se_eq");
    drive(16'h4455, 3); m.reg_addr1 = '0; fin("sne_eq");
    reg_readdata1 = 8'h54;
    drive(16'h3455, 3); m.reg_addr1 = '0; fin("se_ne");
    drive(16'h4455, 3); e.pc_src = PC_SRC_SKIP; m.reg_addr1 = '0; fin("sne_ne");
    drive(16'h00E0, 2); e.fbreset = 1; fin("cls_s2");
    drive(16'h00EE, 2); fin("ret_undec");
    delay_timer_readdata = 8'h9C;
    drive(16'hF307, 2); e.reg_addr1 = 4'h3; e.reg_writedata1 = 8'h9C; e.reg_WE1 = 1; fin("gdt_s2");
    drive(16'hF515, 2); e.reg_addr1 = 4'h5; fin("sdt_s2");
    reg_readdata1 = 8'h77;
    drive(16'hF515, 3); e.delay_timer_WE = 1; e.delay_timer_writedata = 8'h77; m.reg_addr1 = '0; fin("sdt_s3");
    drive(16'hF518, 3); e.sound_timer_WE = 1; e.sound_timer_writedata = 8'h77; m.reg_addr1 = '0; fin("sst_s3");
    key_pressed = 1'b0;
    drive(16'hF60A, 5); e.halt_for_keypress = 1; fin("key_wait");
    key_pressed = 1'b1; key_press = 4'hB;
    drive(16'hF60A, 2); e.reg_addr1 = 4'h6; e.reg_writedata1 = 8'h0B; e.reg_WE1 = 1; fin("key_got");
    drive(16'hF60A, 1); fin("key_s1");
    top_level_state = CHIP8_PAUSED;
    drive(16'h61F0, 2); fin("not_running");
    top_level_state = CHIP8_RUNNING;
    drive(16'h5120, 2); fin("undecoded");
    drive(16'h61F0, 2);
    #1 reset_n = 1'b0;
    now("rst_mid");
    @(negedge cpu_clk) reset_n = 1'b1;
    drive(16'h61F0, 2); e.reg_addr1 = 4'h1; e.reg_writedata1 = 8'hF0; e.reg_WE1 = 1; fin("resume");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/chip8_cpu.md
CHIP8_CPU -- requirements
Module: chip8_cpu

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 cpu_clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 instruction  in  16  current opcode, held stable for the whole instruction.
REQ-005 stage  in  32  cycle index within the instruction; incremented externally each cpu_clk rise; 0 marks a new instruction.
REQ-006 top_level_state  in  Chip8_STATE  system state; the CPU executes only in CHIP8_RUNNING.
REQ-007 reg_readdata1 / reg_readdata2  in  8 each  V-register read data for ports 1 and 2 (combinational read).
REQ-008 mem_readdata1 / mem_readdata2, reg_I_readdata (16), delay_timer_readdata (8), PC_readdata (12), fb_readdata (1)  in  data returns.
REQ-009 key_pressed  in  1  key-down flag; key_press  in  4  key code.
REQ-010 reg_addr1 / reg_addr2  out  4  V-register addresses.
REQ-011 reg_writedata1 / reg_writedata2  out  8, reg_WE1 / reg_WE2  out  1  V-register writes.
REQ-012 mem_addr1 / mem_addr2 (12), mem_writedata1 / mem_writedata2 (8), mem_WE1 / mem_WE2 (1)  out  memory ports.
REQ-013 reg_I_writedata  out  16, reg_I_WE  out  1  I register write.
REQ-014 delay_timer_writedata / sound_timer_writedata (8), delay_timer_WE / sound_timer_WE (1)  out  timer writes.
REQ-015 pc_src  out  PC_SRC  next-PC select; PC_writedata  out  12  jump target.
REQ-016 sp_push / sp_pop  out  1  stack controls.
REQ-017 fb_addr_y (5), fb_addr_x (6), fb_writedata (1), fb_WE (1), fbreset (1)  out  framebuffer controls.
REQ-018 halt_for_keypress  out  1  requests a stall until a key is pressed.

Function
REQ-019 All outputs SHALL be combinational functions of stage, instruction and the readdata inputs; the only state is the async-reset gating.
REQ-020 Default: every output is 0, and pc_src = PC_SRC_NEXT; the defaults apply in every stage not listed below, for undecoded opcodes, and outside CHIP8_RUNNING.
REQ-021 6xkk, stage 2: reg_addr1 = x, reg_writedata1 = kk, reg_WE1 = 1.
REQ-022 7xkk, stage 2: reg_addr1 = x, no write.
REQ-023 7xkk, stage 3: reg_addr1 = x, reg_writedata1 = (reg_readdata1 + kk) mod 256, reg_WE1 = 1; VF is unchanged.
REQ-024 8xy0, stage 2: reg_addr1 = x, reg_addr2 = y.
REQ-025 8xy0, stage 3: reg_addr1 = x, reg_writedata1 = reg_readdata2, reg_WE1 = 1.
REQ-026 8xy4, stage 2: reg_addr1 = x, reg_addr2 = y.
REQ-027 8xy4, stage 3: writes Vx = sum[7:0] via port 1 and VF = carry via port 2 (reg_addr2 = F, reg_WE2 = 1); if x = F, the carry write wins.
REQ-028 1nnn, stage 2: pc_src = PC_SRC_JUMP, PC_writedata = nnn.
REQ-029 Annn, stage 2: reg_I_WE = 1, reg_I_writedata = {4'h0, nnn}.
REQ-030 3xkk/4xkk, stage 2: reg_addr1 = x.
REQ-031 3xkk/4xkk, stage 3: pc_src = PC_SRC_SKIP when reg_readdata1 == kk (3xkk) or != kk (4xkk), otherwise PC_SRC_NEXT.
REQ-032 00E0, stage 2: fbreset = 1.
REQ-033 Fx07, stage 2: reg_addr1 = x, reg_writedata1 = delay_timer_readdata, reg_WE1 = 1.
REQ-034 Fx15/Fx18, stage 2: reg_addr1 = x.
REQ-035 Fx15/Fx18, stage 3: delay_timer_WE (Fx15) or sound_timer_WE (Fx18) = 1, with writedata = reg_readdata1.
REQ-036 Fx0A, stage >= 2 and key_pressed = 0: halt_for_keypress = 1.
REQ-037 Fx0A, stage >= 2 and key_pressed = 1: halt_for_keypress = 0, reg_addr1 = x, reg_writedata1 = {4'h0, key_press}, reg_WE1 = 1.
REQ-038 Stages 0-1 (fetch, owned by the top level) and all stages after an instruction's last active stage: defaults.

Reset
REQ-039 While reset_n = 0, all outputs SHALL be forced to the defaults immediately (asynchronously), regardless of stage.
REQ-040 Deassertion mid-instruction resumes decoding at the current stage value; no write is replayed.

Structure
REQ-041 The enums Chip8_STATE and PC_SRC (PC_SRC_NEXT, PC_SRC_JUMP, PC_SRC_SKIP) and the opcode nibble constants SHALL live in the shared package chip8_pkg.
REQ-042 The block is a single module; an optional sub-module chip8_alu implements add-with-carry for 7xkk and 8xy4.

Verification
REQ-043 61F0 at stage 2 -> reg_addr1 = 1, reg_writedata1 = F0, reg_WE1 = 1; stage 3 -> all outputs at defaults.
REQ-044 7EF0 with reg_readdata1 = 01 -> stage 2: reg_addr1 = E, reg_WE1 = 0; stage 3: reg_writedata1 = F1, reg_WE1 = 1; stage 4 -> defaults.
REQ-045 7302 with reg_readdata1 = FF -> stage 3: reg_writedata1 = 01, reg_WE2 = 0.
REQ-046 8124 with readdata1 = F0, readdata2 = 20 -> stage 3: reg_writedata1 = 10, reg_addr2 = F, reg_writedata2 = 01, reg_WE2 = 1.
REQ-047 A123 at stage 2 -> reg_I_WE = 1, reg_I_writedata = 0123; 1ABC at stage 2 -> pc_src = PC_SRC_JUMP, PC_writedata = ABC.
REQ-048 61F0 at stage 2 with reset_n driven low -> all outputs at defaults within the same cycle.
